// File: rtl/io_input_pkg.sv
// ---------------------------------------------------------------------------
// io_input_pkg
// Shared definitions for the IO board input conditioner: the debounce FSM
// state encoding, default timing constants and the channel counts.
// No ports (package).
// ---------------------------------------------------------------------------
package io_input_pkg;

    // Debounce FSM: STABLE while the synchronized pin agrees with the
    // committed level, COUNT while a candidate new value is being timed.
    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_t;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    // 500 ms until the first auto-repeat, then every 100 ms
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

    localparam int NUM_PB  = 4;
    localparam int NUM_DSW = 8;

endpackage

// File: rtl/io_input_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One input channel: 2-flop synchronizer, polarity inversion and a debounce
// FSM with a stability counter. The committed level only changes after the
// synchronized value has differed from it for DEBOUNCE_CYCLES consecutive
// samples.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to commit (>= 2)
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   raw_n  in   raw active-low pin
//   level  out  committed active-high level (registered)
//   rise   out  one-cycle pulse on a 0->1 commit (registered)
//   fall   out  one-cycle pulse on a 1->0 commit (registered)
// ---------------------------------------------------------------------------
module debounce_channel
    import io_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sample;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    // Synchronizer resets to the released/off pin value so that nothing
    // looks pressed while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], raw_n};
        end
    end

    assign sample = ~sync_q[1];

    // The counter is loaded with 1 on entry to COUNT because the entering
    // sample is already the first stable sample of the new value; this puts
    // the commit exactly DEBOUNCE_CYCLES samples after the change appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE: begin
                    if (sample != level) begin
                        state <= COUNT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                COUNT: begin
                    if (sample == level) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        level <= sample;
                        rise  <= sample;
                        fall  <= ~sample;
                        cnt   <= '0;
                        state <= STABLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/io_input_debounce.sv
// ---------------------------------------------------------------------------
// io_input_debounce
// Conditions the IO board pushbuttons and DIP switches: every pin gets its
// own synchronizer and debouncer, and the block delivers clean active-high
// levels plus press/release/change pulses.
//
// Build option:
//   IO_DEBOUNCE_REPEAT_EN  when defined, a held pushbutton produces extra
//                          PB_PRESS pulses REPEAT_DELAY cycles after the
//                          press and then every REPEAT_PERIOD cycles.
//
// Ports:
//   M_CLOCK     in   system clock
//   M_RESET_N   in   asynchronous active-low reset
//   IO_PB       in   [4] raw pushbuttons, 0 = pressed
//   IO_DSW      in   [8] raw DIP switches, 0 = on
//   PB_LEVEL    out  [4] debounced pushbuttons, 1 = pressed
//   PB_PRESS    out  [4] press pulse (and repeat pulses if enabled)
//   PB_RELEASE  out  [4] release pulse
//   DSW_LEVEL   out  [8] debounced switches, 1 = on
//   DSW_CHANGE  out  pulse when any switch commits a change
// ---------------------------------------------------------------------------
module io_input_debounce
    import io_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic               M_CLOCK,
    input  logic               M_RESET_N,
    input  logic [NUM_PB-1:0]  IO_PB,
    input  logic [NUM_DSW-1:0] IO_DSW,
    output logic [NUM_PB-1:0]  PB_LEVEL,
    output logic [NUM_PB-1:0]  PB_PRESS,
    output logic [NUM_PB-1:0]  PB_RELEASE,
    output logic [NUM_DSW-1:0] DSW_LEVEL,
    output logic               DSW_CHANGE
);

    logic [NUM_PB-1:0]  pb_rise;
    logic [NUM_DSW-1:0] dsw_rise;
    logic [NUM_DSW-1:0] dsw_fall;

    for (genvar i = 0; i < NUM_PB; i++) begin : g_pb
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_channel (
            .clk   (M_CLOCK),
            .rst_n (M_RESET_N),
            .raw_n (IO_PB[i]),
            .level (PB_LEVEL[i]),
            .rise  (pb_rise[i]),
            .fall  (PB_RELEASE[i])
        );
    end

    for (genvar i = 0; i < NUM_DSW; i++) begin : g_dsw
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_channel (
            .clk   (M_CLOCK),
            .rst_n (M_RESET_N),
            .raw_n (IO_DSW[i]),
            .level (DSW_LEVEL[i]),
            .rise  (dsw_rise[i]),
            .fall  (dsw_fall[i])
        );
    end

    // Simultaneous commits on several switches collapse into one pulse.
    assign DSW_CHANGE = |(dsw_rise | dsw_fall);

`ifdef IO_DEBOUNCE_REPEAT_EN
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    logic [NUM_PB-1:0][31:0] rep_cnt;
    logic [NUM_PB-1:0]       rep_first;
    logic [NUM_PB-1:0]       rep_pulse;

    // The repeat counter idles at 0 while the button is released, so in the
    // commit cycle it reads 0 and reaches REPEAT_DELAY-1 one cycle before
    // the first repeat pulse. rep_first selects the initial delay versus the
    // steady repeat period.
    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            rep_cnt   <= '0;
            rep_first <= '1;
            rep_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_PB; i++) begin
                if (!PB_LEVEL[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b1;
                    rep_pulse[i] <= 1'b0;
                end else if (rep_cnt[i] == (rep_first[i] ? DELAY_LAST : PERIOD_LAST)) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                    rep_pulse[i] <= 1'b1;
                end else begin
                    rep_cnt[i]   <= rep_cnt[i] + 32'd1;
                    rep_pulse[i] <= 1'b0;
                end
            end
        end
    end

    // A repeat that would land in the release-commit cycle is masked by the
    // already-cleared level.
    assign PB_PRESS = pb_rise | (rep_pulse & PB_LEVEL);
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

    assign PB_PRESS = pb_rise;
`endif

endmodule

// File: tb/tb_io_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_io_input_debounce
// Scoreboard bench for io_input_debounce with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5. Stimulus pushes the expected output
// state for the cycle in which each commit must appear; a monitor checks the
// full output bundle every cycle, popping entries as their cycle arrives.
// Honors IO_DEBOUNCE_REPEAT_EN for the auto-repeat expectations.
// ---------------------------------------------------------------------------
module tb_io_input_debounce;

    localparam int DB     = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 5;

    logic       M_CLOCK;
    logic       M_RESET_N;
    logic [3:0] IO_PB;
    logic [7:0] IO_DSW;
    logic [3:0] PB_LEVEL;
    logic [3:0] PB_PRESS;
    logic [3:0] PB_RELEASE;
    logic [7:0] DSW_LEVEL;
    logic       DSW_CHANGE;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] pb_level;
        logic [3:0] pb_press;
        logic [3:0] pb_release;
        logic [7:0] dsw_level;
        logic       dsw_change;
    } sb_entry_t;

    sb_entry_t  sb_q[$];
    int         cyc;
    int         num_checks;
    int         num_failures;
    logic [3:0] stim_pb;
    logic [7:0] stim_dsw;
    logic [3:0] exp_pb;
    logic [7:0] exp_dsw;

    io_input_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .M_CLOCK    (M_CLOCK),
        .M_RESET_N  (M_RESET_N),
        .IO_PB      (IO_PB),
        .IO_DSW     (IO_DSW),
        .PB_LEVEL   (PB_LEVEL),
        .PB_PRESS   (PB_PRESS),
        .PB_RELEASE (PB_RELEASE),
        .DSW_LEVEL  (DSW_LEVEL),
        .DSW_CHANGE (DSW_CHANGE)
    );

    initial begin
        M_CLOCK = 1'b0;
        forever #5 M_CLOCK = ~M_CLOCK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_failures++;
            $display("[TB] FAIL %s cycle=%0d actual=0x%0h expected=0x%0h",
                     tag, cyc, actual, expected);
        end
    endtask

    // Drives held pin values and, if they change the eventual debounced
    // state, schedules the commit DB+2 edges later.
    task automatic applyStimulus(input logic [3:0] pb, input logic [7:0] dsw,
                                 input string tag);
        sb_entry_t  e;
        logic [3:0] nl;
        logic [7:0] nd;
        IO_PB  = pb;
        IO_DSW = dsw;
        nl = ~pb;
        nd = ~dsw;
        if (nl != stim_pb || nd != stim_dsw) begin
            e.cyc        = cyc + DB + 2;
            e.tag        = tag;
            e.pb_level   = nl;
            e.pb_press   = nl & ~stim_pb;
            e.pb_release = ~nl & stim_pb;
            e.dsw_level  = nd;
            e.dsw_change = (nd != stim_dsw);
            sb_q.push_back(e);
            stim_pb  = nl;
            stim_dsw = nd;
        end
    endtask

    task automatic pushRepeat(input int at_cyc);
        sb_entry_t e;
        e.cyc        = at_cyc;
        e.tag        = "pb3_repeat";
        e.pb_level   = stim_pb;
        e.pb_press   = 4'b1000;
        e.pb_release = 4'b0000;
        e.dsw_level  = stim_dsw;
        e.dsw_change = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge M_CLOCK);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge M_CLOCK) begin
        logic [31:0] act;
        sb_entry_t   e;
        cyc++;
        #1;
        act = 32'({PB_LEVEL, PB_PRESS, PB_RELEASE, DSW_LEVEL, DSW_CHANGE});
        if (!M_RESET_N) begin
            exp_pb  = '0;
            exp_dsw = '0;
            checkOutput("reset_outputs", act, 32'd0);
        end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            checkOutput({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
            exp_pb  = e.pb_level;
            exp_dsw = e.dsw_level;
            checkOutput(e.tag, act, 32'({e.pb_level, e.pb_press, e.pb_release,
                                         e.dsw_level, e.dsw_change}));
        end else begin
            checkOutput("idle", act, 32'({exp_pb, 4'b0000, 4'b0000, exp_dsw, 1'b0}));
        end
    end

    initial begin
        int c_press;
        cyc          = 0;
        num_checks   = 0;
        num_failures = 0;
        stim_pb      = '0;
        stim_dsw     = '0;
        exp_pb       = '0;
        exp_dsw      = '0;
        IO_PB        = 4'hF;
        IO_DSW       = 8'hFF;
        M_RESET_N    = 1'b0;

        // Reset with everything released: outputs stay quiet.
        waitCycles(5);
        M_RESET_N = 1'b1;
        waitCycles(20);

        // Single press and release of PB0.
        applyStimulus(4'hE, 8'hFF, "pb0_press");
        waitCycles(10);
        applyStimulus(4'hF, 8'hFF, "pb0_release");
        waitCycles(10);

        // Bouncing PB1: never stable for 4 samples.
        for (int k = 0; k < 10; k++) begin
            IO_PB = 4'hD;
            waitCycles(3);
            IO_PB = 4'hF;
            waitCycles(1);
        end
        waitCycles(10);

        // Two switches change together, then return.
        applyStimulus(4'hF, 8'hF6, "dsw_on");
        waitCycles(10);
        applyStimulus(4'hF, 8'hFF, "dsw_off");
        waitCycles(10);

        // Reset two cycles into the PB2 count, button kept held.
        IO_PB = 4'hB;
        waitCycles(4);
        M_RESET_N = 1'b0;
        sb_q.delete();
        stim_pb  = '0;
        stim_dsw = '0;
        waitCycles(3);
        M_RESET_N = 1'b1;
        applyStimulus(4'hB, 8'hFF, "pb2_after_reset");
        waitCycles(10);
        applyStimulus(4'hF, 8'hFF, "pb2_release");
        waitCycles(10);

        // PB3 held for 40 cycles.
        c_press = cyc + DB + 2;
        applyStimulus(4'h7, 8'hFF, "pb3_press");
`ifdef IO_DEBOUNCE_REPEAT_EN
        for (int t = c_press + DELAY; t < c_press + 40; t += PERIOD) begin
            pushRepeat(t);
        end
`endif
        waitCycles(40);
        applyStimulus(4'hF, 8'hFF, "pb3_release");
        waitCycles(12);

        checkOutput("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
        $finish;
    end

endmodule
